// File: rtl/spi_pwm_pkg.sv
// Shared constants and types for the SPI configuration port of the PWM peripheral.
package spi_pwm_pkg;

  localparam int FRAME_W  = 16;
  localparam int NUM_REGS = 5;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

  localparam int          CNT_W    = 5;
  localparam logic [4:0]  CNT_FULL = 5'd16;
  localparam logic [4:0]  CNT_OVER = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit synchroniser of configurable depth; RST_VAL sets the idle level held during reset.
module sync_2ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {STAGES{RST_VAL}};
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_pwm_config.sv
// SPI mode-0 peripheral writing the PWM register file; pins are oversampled in the clk domain.
// Optional readback on cipo is built when SPI_READBACK_EN is defined.
module spi_pwm_config #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = spi_pwm_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              cipo,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle
);

  import spi_pwm_pkg::*;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_d, ncs_d;
  logic [SYNC_STAGES:0] flush_sr;
  logic armed;

  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));
  sync_2ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s));

  // armed only after the synchroniser has flushed its reset value and ncs was seen high,
  // so a chip select held low across reset release cannot start a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d   <= 1'b0;
      ncs_d    <= 1'b1;
      flush_sr <= '0;
      armed    <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      ncs_d    <= ncs_s;
      flush_sr <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
      armed    <= armed | (flush_sr[SYNC_STAGES] & ncs_s);
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_fall  = armed & ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;

  state_t state, state_nxt;
  logic [FRAME_W-1:0] shift_q, shift_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic frame_start, take_bit, frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ncs_fall) state_nxt = RECV;
      RECV: begin
        if (ncs_rise)                            state_nxt = IDLE;
        else if (sclk_rise && cnt_q == CNT_FULL) state_nxt = OVER;
      end
      OVER: if (ncs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    take_bit    = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: frame_start = ncs_fall;
      RECV: begin
        take_bit  = sclk_rise;
        frame_end = ncs_rise;
      end
      default: ;
    endcase
  end

  // a bit arriving in the same cycle as ncs_rise is shifted before the commit decision
  logic [ADDR_W-1:0] addr_f;
  logic [DATA_W-1:0] data_f;
  logic              commit;

  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    if (take_bit) begin
      shift_nxt = {shift_q[FRAME_W-2:0], copi_s};
      cnt_nxt   = (cnt_q == CNT_OVER) ? cnt_q : cnt_q + 5'd1;
    end
  end

  assign addr_f = shift_nxt[FRAME_W-2 -: ADDR_W];
  assign data_f = shift_nxt[DATA_W-1:0];
  assign commit = frame_end && (cnt_nxt == CNT_FULL) && shift_nxt[FRAME_W-1]
                  && (addr_f < ADDR_W'(NUM_REGS));

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (frame_start) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (take_bit) begin
        shift_q <= shift_nxt;
        cnt_q   <= cnt_nxt;
      end
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && addr_f == ADDR_W'(i)) regs[i] <= data_f;
    end
  end

  assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs[ADDR_DUTY];

`ifdef SPI_READBACK_EN
  // after 8 bits the low ADDR_W bits of the shifter hold the address and the bit above is R/W
  logic              sclk_fall, rd_load, rd_adv;
  logic [DATA_W-1:0] rd_data, out_sr;

  assign sclk_fall = ~sclk_s & sclk_d;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (shift_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs[i];
  end

  assign rd_load = take_bit && (cnt_nxt == 5'd8) && !shift_nxt[ADDR_W];
  assign rd_adv  = (state == RECV) && sclk_fall && (cnt_q >= 5'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      out_sr <= '0;
    else if (ncs_rise || frame_start) out_sr <= '0;
    else if (rd_load)                out_sr <= rd_data;
    else if (rd_adv)                 out_sr <= {out_sr[DATA_W-2:0], 1'b0};
  end

  assign cipo = out_sr[DATA_W-1];
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_config.sv
// Directed bench for spi_pwm_config: frame-level register model plus per-cycle output compare.
module tb_spi_pwm_config;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic       cipo;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;

  spi_pwm_config #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi), .pwm_duty_cycle(duty)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          shown = 0;
  bit          settling = 1'b1;
  bit          busy = 1'b0;
  logic [7:0]  model [5];
  logic [15:0] cap;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name, input logic [39:0] exp);
    check8({name, ".out_lo"}, out_lo, exp[39:32]);
    check8({name, ".out_hi"}, out_hi, exp[31:24]);
    check8({name, ".pwm_lo"}, pwm_lo, exp[23:16]);
    check8({name, ".pwm_hi"}, pwm_hi, exp[15:8]);
    check8({name, ".duty"},   duty,   exp[7:0]);
  endtask

  // Drives nbits of a frame MSB first; cap records cipo as the master samples it on each rise.
  task automatic frame(input logic [15:0] f, input int nbits, input bit close);
    int a;
    busy = 1'b1;
    cap  = '0;
    ncs  = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? f[15-i] : 1'b0;
      tick(HALF);
      if (i < 16) cap[15-i] = cipo;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    if (close) begin
      tick(HALF);
      ncs      = 1'b1;
      settling = 1'b1;
      tick(SYNC + 2);
      a = int'(f[14:8]);
      if (nbits == 16 && f[15] && a < 5) model[a] = f[7:0];
      settling = 1'b0;
      busy     = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!settling) begin
      n_vec++;
      if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !==
          {model[0], model[1], model[2], model[3], model[4]}) begin
        n_err++;
        if (shown < 20) begin
          shown++;
          $display("FAIL regs @%0t: got %h %h %h %h %h expected %h %h %h %h %h", $time,
                   out_lo, out_hi, pwm_lo, pwm_hi, duty,
                   model[0], model[1], model[2], model[3], model[4]);
        end
      end
`ifdef SPI_READBACK_EN
      if (!busy) begin
`else
      begin
`endif
        n_vec++;
        if (cipo !== 1'b0) begin
          n_err++;
          if (shown < 20) begin
            shown++;
            $display("FAIL cipo_idle @%0t: got %b expected 0", $time, cipo);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ncs   = 1'b1;
    sclk  = 1'b0;
    copi  = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    settling = 1'b0;
    tick(3);
    check_regs("reset", 40'h00_00_00_00_00);
    check8("reset.cipo", {7'd0, cipo}, 8'h00);
    rst_n = 1'b1;
    tick(6);

    frame(16'h80F0, 16, 1'b1);
    check_regs("wr_out_lo", 40'hF0_00_00_00_00);

    frame(16'h8480, 16, 1'b1);
    check_regs("wr_duty", 40'hF0_00_00_00_80);

    frame(16'h85FF, 16, 1'b1);
    check_regs("wr_addr5", 40'hF0_00_00_00_80);

    frame(16'h81AA, 12, 1'b1);
    check_regs("short", 40'hF0_00_00_00_80);
    frame(16'h81AA, 17, 1'b1);
    check_regs("long", 40'hF0_00_00_00_80);

    frame(16'h83FF, 9, 1'b0);
    rst_n = 1'b0;
    ncs   = 1'b1;
    sclk  = 1'b0;
    copi  = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    busy  = 1'b0;
    tick(3);
    check_regs("rst_mid", 40'h00_00_00_00_00);
    rst_n = 1'b1;
    tick(6);
    frame(16'h83FF, 16, 1'b1);
    check_regs("wr_pwm_hi", 40'h00_00_00_FF_00);

    frame(16'h82AA, 16, 1'b1);
    check_regs("wr_pwm_lo", 40'h00_00_AA_FF_00);
    frame(16'h0200, 16, 1'b1);
`ifdef SPI_READBACK_EN
    check8("readback", cap[7:0], 8'hAA);
    check8("readback_hdr", cap[15:8], 8'h00);
`else
    check8("cipo_lo", cap[7:0], 8'h00);
    check8("cipo_hi", cap[15:8], 8'h00);
`endif
    check_regs("after_read", 40'h00_00_AA_FF_00);

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
